// File: rtl/ahb_lite_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_slave_mem_if
// Description : AHB-Lite bus bundle between one master (or interconnect) and
//               the ahb_lite_slave_mem responder.
//               master modport drives the address/control/write-data and the
//               bus-wide hready; slave modport returns hrdata, hreadyout and
//               hresp.
// Ports       : hsel, haddr, htrans, hwrite, hsize, hwdata, hready (to slave)
//               hrdata, hreadyout, hresp                      (from slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_lite_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_slave_mem
// Description : AHB-Lite responder backed by a word-organised SRAM. Accepts
//               pipelined SINGLE/INCR transfers, inserts WAIT_STATES
//               hreadyout-low cycles per OKAY data phase and answers illegal
//               transfers with the two-cycle ERROR response.
// Parameters  : ADDR_WIDTH, DATA_WIDTH (32/64), MEM_DEPTH (words, power of 2),
//               WAIT_STATES (0..15)
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active high
//               wr_protect - write protect (only with AHB_SLV_WPROT_EN)
//               bus        - ahb_lite_slave_mem_if.slave bundle
// Options     : `define AHB_SLV_WPROT_EN adds the wr_protect port; writes
//               accepted while it is high return ERROR and leave memory as is.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef AHB_SLV_WPROT_EN
    input  logic                 wr_protect,
`endif
    ahb_lite_slave_mem_if.slave  bus
);

    localparam int c_bytes = DATA_WIDTH / 8;
    localparam int c_off_w = $clog2(c_bytes);
    localparam int c_idx_w = $clog2(MEM_DEPTH);
    localparam int c_adr_w = c_off_w + c_idx_w;
    localparam logic [ADDR_WIDTH:0] c_limit = (ADDR_WIDTH+1)'(MEM_DEPTH * c_bytes);
    localparam logic [3:0] c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                state_q,    state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [c_adr_w-1:0]    addr_q,     addr_d;
    logic                  write_q,    write_d;
    logic [2:0]            size_q,     size_d;
    logic [DATA_WIDTH-1:0] hrdata_q,   hrdata_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_wprot;
    logic                  w_wr_en;
    logic [c_bytes-1:0]    w_be;
    logic [c_off_w-1:0]    w_off;
    logic [c_idx_w-1:0]    w_wr_idx;
    logic [c_idx_w-1:0]    w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused;

    // htrans[0] only separates NONSEQ from SEQ, which this target treats alike
    assign w_unused = bus.htrans[0];

    // A new address phase can only be taken while our own data phase is not
    // stalling; gating with w_ready keeps the FSM safe if hready is misdriven.
    assign w_ready  = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign w_accept = bus.hsel && bus.hready && bus.htrans[1] && w_ready;

`ifdef AHB_SLV_WPROT_EN
    assign w_wprot = bus.hwrite && wr_protect;
`else
    assign w_wprot = 1'b0;
`endif

    assign w_err = ((bus.haddr & ~({ADDR_WIDTH{1'b1}} << bus.hsize)) != '0) ||
                   (bus.hsize > 3'(c_off_w)) ||
                   ({1'b0, bus.haddr} >= c_limit) ||
                   w_wprot;

    assign w_off    = addr_q[c_off_w-1:0];
    assign w_wr_idx = addr_q[c_off_w +: c_idx_w];
    assign w_rd_idx = (state_q == ST_WAIT) ? addr_q[c_off_w +: c_idx_w]
                                           : bus.haddr[c_off_w +: c_idx_w];
    assign w_wr_en  = (state_q == ST_DATA) && write_q;

    // Little-endian byte lanes covered by the beat held in the data phase
    always_comb begin
        w_be = '0;
        for (int i = 0; i < c_bytes; i++) begin
            w_be[i] = (i >= int'(w_off)) && (i < int'(w_off) + (1 << size_q));
        end
    end

    // Read port with forwarding: a read accepted on the edge that retires a
    // write to the same word must see the freshly written bytes.
    always_comb begin
        w_rd_word = mem[w_rd_idx];
        if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
            for (int i = 0; i < c_bytes; i++) begin
                if (w_be[i]) begin
                    w_rd_word[8*i +: 8] = bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        hrdata_d   = hrdata_q;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                    if (!write_q) begin
                        hrdata_d = w_rd_word;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all end with hreadyout=1 and may take
                // the next pipelined address phase.
                state_d = ST_IDLE;
                if (w_accept) begin
                    addr_d  = bus.haddr[c_adr_w-1:0];
                    write_d = bus.hwrite;
                    size_d  = bus.hsize;
                    if (w_err) begin
                        state_d  = ST_ERR1;
                        hrdata_d = '0;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = c_wait_init;
                    end else begin
                        state_d = ST_DATA;
                        if (!bus.hwrite) begin
                            hrdata_d = w_rd_word;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
            hrdata_q   <= hrdata_d;
        end
    end

    // Backing store is not reset; a reset during the data phase drops the write
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            for (int i = 0; i < c_bytes; i++) begin
                if (w_be[i]) begin
                    mem[w_wr_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = w_ready;
    assign bus.hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign bus.hrdata    = hrdata_q;

endmodule
`default_nettype wire
